// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter: FSM state encoding and id width.
// No logic of its own; imported by rom_arb_select and rom_read_arbiter.
// Helper id_w() keeps a requester index at least one bit wide.
package rom_arb_pkg;

    // One hop per state: IDLE -> READ -> CAPTURE -> RESP -> (READ | IDLE)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Width of a requester index for n requesters
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rom_arb_select.sv
// Winner selection for the ROM read arbiter (fixed priority or round-robin).
// Latency: combinational; only the round-robin pointer is a register.
// Backpressure: none; the pointer advances only when the caller asserts take.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (pointer only)
//   req       - request vector, one bit per requester
//   take      - the caller is granting win_idx on this edge
//   any_req   - at least one request is present
//   win_idx   - index of the selected requester (valid when any_req)
//
// Policy macro: ROM_ARB_ROUND_ROBIN_EN defined selects round-robin, otherwise
// fixed priority with the lowest index winning.
module rom_arb_select
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               any_req,
    output logic [ID_W-1:0]    win_idx
);

    assign any_req = |req;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // Last granted index; reset to NUM_REQ-1 so requester 0 is searched first
    logic [ID_W-1:0]      ptr_q;
    logic [2*NUM_REQ-1:0] req2;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      pos;
    int                   sum_idx;

    // Rotate the doubled request vector so bit 0 is the slot after ptr_q,
    // take the lowest set bit, then map the offset back to an absolute index.
    always_comb begin
        req2    = {req, req};
        rot     = NUM_REQ'(req2 >> (int'(ptr_q) + 1));
        pos     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = ID_W'(i);
        end
        sum_idx = int'(ptr_q) + 1 + int'(pos);
        if (sum_idx >= NUM_REQ) sum_idx = sum_idx - NUM_REQ;
        win_idx = ID_W'(sum_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (take) begin
            ptr_q <= win_idx;
        end
    end
`else
    // Lowest set index wins; scanning downwards leaves the lowest one last
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = ID_W'(i);
        end
    end

    // Fixed priority holds no state
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, take};
`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates NUM_REQ requesters onto one ROM read port and returns the data.
// Latency: grant the cycle after req is sampled; rsp_valid two cycles later.
// Backpressure: RESP holds rsp_* until rsp_ready; no new grant meanwhile.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   req, req_addr     - per-requester request (held until granted) and address
//   gnt               - one-hot, one-cycle grant pulse (first cycle of READ)
//   rsp_valid/_ready  - response handshake; rsp_id/rsp_data hold the response
//   busy              - high in any state but IDLE
//   rom_en, rom_addr  - ROM read port; rom_data returns one cycle after rom_en
//
// Build option: ROM_ARB_ROUND_ROBIN_EN selects round-robin arbitration,
// otherwise fixed priority (lowest index first).
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [id_w(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int ID_W = id_w(NUM_REQ);

    state_t              state_q, state_d;

    // Registered outputs and their next values
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic                rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;

    // Id of the transaction in flight; rom_addr_q doubles as its latched address
    logic [ID_W-1:0]     cur_id_q, cur_id_d;

    logic                any_req;
    logic [ID_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [ADDR_W-1:0]   win_addr;
    logic                take;

    rom_arb_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_select (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .take    (take),
        .any_req (any_req),
        .win_idx (win_idx)
    );

    assign win_addr = req_addr[int'(win_idx) * ADDR_W +: ADDR_W];

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (win_idx == ID_W'(i));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        cur_id_d    = cur_id_q;
        take        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                take = any_req;
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // ROM output is valid now, one cycle after rom_en was sampled
                rsp_data_d  = rom_data;
                rsp_id_d    = cur_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Arbitrate on the handshake edge so back-to-back reads
                    // cost three cycles each
                    take        = any_req;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            state_d    = ST_READ;
            gnt_d      = win_onehot;
            rom_en_d   = 1'b1;
            rom_addr_d = win_addr;
            cur_id_d   = win_idx;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            cur_id_q    <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            cur_id_q    <= cur_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter with a 1-cycle ROM (location k = 16'h1000+k).
// Expected grants and responses are queued when stimulus is driven and
// popped as the DUT grants and hands over responses.
module tb_rom_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic                      rom_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;

    rom_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    // ROM model, one cycle of latency
    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= 16'h1000 + {12'h000, rom_addr};
    end

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t               exp_rsp_q[$];
    logic [NUM_REQ-1:0] exp_gnt_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rom_en_cnt  = 0;
    int hs_cnt      = 0;
    int gnt1_cnt    = 0;

    // Advance one cycle; sample at the falling edge and run the scoreboard
    task automatic tick();
        logic               hs;
        rsp_t               got;
        rsp_t               e;
        logic [NUM_REQ-1:0] g;
        // Handshake state presented to the coming rising edge
        hs  = rsp_valid && rsp_ready && !rst;
        got = {rsp_id, rsp_data};
        @(negedge clk);
        cyc++;
        if (rom_en === 1'b1) rom_en_cnt++;
        if (gnt[1] === 1'b1) gnt1_cnt++;
        if (hs) begin
            hs_cnt++;
            vectors++;
            if (exp_rsp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", got.id, got.data);
            end else begin
                e = exp_rsp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL rsp_scoreboard: got id=%0d data=%h, required id=%0d data=%h",
                             got.id, got.data, e.id, e.data);
                end
            end
        end
        if (gnt !== '0 && !$isunknown(gnt)) begin
            vectors++;
            if (exp_gnt_q.size() == 0) begin
                miscompares++;
                $display("FAIL gnt_unexpected: got %b, required 0000", gnt);
            end else begin
                g = exp_gnt_q.pop_front();
                if (gnt !== g) begin
                    miscompares++;
                    $display("FAIL gnt_scoreboard: got %b, required %b", gnt, g);
                end
            end
            vectors++;
            if (rom_en !== 1'b1) begin
                miscompares++;
                $display("FAIL gnt_in_read: rom_en=%b with gnt, required 1", rom_en);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_addr = '0; rsp_ready = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({gnt, rsp_valid, rsp_id, rsp_data, busy, rom_en, rom_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b vld=%b id=%0d data=%h busy=%b en=%b addr=%h, required all 0",
                     gnt, rsp_valid, rsp_id, rsp_data, busy, rom_en, rom_addr);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({busy, gnt, rom_en} !== '0) begin
            miscompares++;
            $display("FAIL idle_hold: busy=%b gnt=%b en=%b, required 0", busy, gnt, rom_en);
        end
    endtask

    // One requester alone: grant next cycle, rsp_valid 3 cycles after req
    task automatic test_single(input int idx, input int addr);
        logic [NUM_REQ-1:0] oh;
        logic [ADDR_W-1:0]  a;
        rsp_t               e;
        int                 start, gc, vc;
        oh = 4'b0001 << idx;
        a  = addr[ADDR_W-1:0];
        e.id   = idx[ID_W-1:0];
        e.data = 16'h1000 + {12'h000, a};
        exp_gnt_q.push_back(oh);
        exp_rsp_q.push_back(e);
        req_addr[idx*ADDR_W +: ADDR_W] = a;
        rsp_ready = 1'b1;
        req   = oh;
        start = cyc; gc = -1; vc = -1;
        for (int k = 0; k < 12 && vc < 0; k++) begin
            tick();
            if (gnt !== '0 && gc < 0) begin
                gc = cyc - start;
                req = '0;
                vectors++;
                if (rom_addr !== a) begin
                    miscompares++;
                    $display("FAIL single_rom_addr: got %h, required %h", rom_addr, a);
                end
            end
            if (rsp_valid === 1'b1 && vc < 0) vc = cyc - start;
        end
        vectors++;
        if (gc != 1) begin
            miscompares++;
            $display("FAIL single_gnt_latency: got %0d, required 1", gc);
        end
        vectors++;
        if (vc != 3) begin
            miscompares++;
            $display("FAIL single_rsp_latency: got %0d, required 3", vc);
        end
        tick();
        vectors++;
        if ({busy, rsp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_back_to_idle: busy=%b vld=%b, required 0 0", busy, rsp_valid);
        end
    endtask

    // All four requesting continuously, rsp_ready high
    task automatic test_all_req();
        logic [ADDR_W-1:0] addr_tab [NUM_REQ];
        int                ids [5];
        int                gcyc [$];
        int                n, hs0;
        rsp_t              e;
        addr_tab = '{4'd0, 4'd5, 4'd10, 4'd15};
`ifdef ROM_ARB_ROUND_ROBIN_EN
        ids = '{0, 1, 2, 3, 0};
`else
        ids = '{0, 0, 0, 0, 0};
`endif
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        for (int k = 0; k < 5; k++) begin
            exp_gnt_q.push_back(4'b0001 << ids[k]);
            e.id   = ids[k][ID_W-1:0];
            e.data = 16'h1000 + {12'h000, addr_tab[ids[k]]};
            exp_rsp_q.push_back(e);
        end
        hs0 = hs_cnt; n = 0;
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 40 && (hs_cnt - hs0) < 5; k++) begin
            tick();
            if (gnt !== '0) begin
                gcyc.push_back(cyc);
                n++;
                if (n == 5) req = '0;
            end
        end
        vectors++;
        if (n != 5 || (hs_cnt - hs0) != 5) begin
            miscompares++;
            $display("FAIL all_req_count: grants=%0d responses=%0d, required 5 5", n, hs_cnt - hs0);
        end
        for (int k = 1; k < gcyc.size(); k++) begin
            vectors++;
            if (gcyc[k] - gcyc[k-1] != 3) begin
                miscompares++;
                $display("FAIL all_req_throughput: grant gap %0d, required 3", gcyc[k] - gcyc[k-1]);
            end
        end
    endtask

    // Stall in RESP, a new request waits, release grants on the handshake edge
    task automatic test_backpressure();
        rsp_t e;
        exp_gnt_q.push_back(4'b0010);
        e.id = 2'd1; e.data = 16'h1007;
        exp_rsp_q.push_back(e);
        req_addr[7:4] = 4'd7;
        rsp_ready = 1'b0;
        req = 4'b0010;
        for (int k = 0; k < 10 && rsp_valid !== 1'b1; k++) begin
            tick();
            if (gnt !== '0) req = '0;
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_timeout: rsp_valid=%b, required 1", rsp_valid);
        end
        req_addr[11:8] = 4'd9;
        req = 4'b0100;
        exp_gnt_q.push_back(4'b0100);
        e.id = 2'd2; e.data = 16'h1009;
        exp_rsp_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, 2'd1, 16'h1007, 4'b0000}) begin
                miscompares++;
                $display("FAIL bp_stall: vld=%b id=%0d data=%h gnt=%b, required 1 1 1007 0000",
                         rsp_valid, rsp_id, rsp_data, gnt);
            end
        end
        rsp_ready = 1'b1;
        tick();
        req = '0;
        vectors++;
        if ({gnt, rsp_valid} !== {4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_release: gnt=%b vld=%b, required 0100 0", gnt, rsp_valid);
        end
        for (int k = 0; k < 10 && exp_rsp_q.size() != 0; k++) tick();
        vectors++;
        if (exp_rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_second_rsp: pending %0d, required 0", exp_rsp_q.size());
        end
    endtask

    // Reset while in CAPTURE abandons the read
    task automatic test_reset_capture();
        exp_gnt_q.push_back(4'b0001);
        req_addr[3:0] = 4'd4;
        rsp_ready = 1'b1;
        req = 4'b0001;
        for (int k = 0; k < 10 && gnt === '0; k++) tick();
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({gnt, rsp_valid, rsp_id, rsp_data, busy, rom_en, rom_addr} !== '0) begin
            miscompares++;
            $display("FAIL rst_capture_outputs: gnt=%b vld=%b id=%0d data=%h busy=%b en=%b addr=%h, required all 0",
                     gnt, rsp_valid, rsp_id, rsp_data, busy, rom_en, rom_addr);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_capture_no_rsp: vld=%b, required 0", rsp_valid);
            end
        end
        vectors++;
        if (exp_gnt_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_capture_gnt: pending %0d, required 0", exp_gnt_q.size());
        end
    endtask

    // req1 pulsed during READ must never be granted
    task automatic test_ignore_pulse();
        rsp_t e;
        int   en0, hs0, g10;
        en0 = rom_en_cnt; hs0 = hs_cnt; g10 = gnt1_cnt;
        exp_gnt_q.push_back(4'b0001);
        e.id = 2'd0; e.data = 16'h1006;
        exp_rsp_q.push_back(e);
        req_addr[3:0] = 4'd6;
        req_addr[7:4] = 4'd2;
        rsp_ready = 1'b1;
        req = 4'b0001;
        for (int k = 0; k < 10 && gnt === '0; k++) tick();
        req = 4'b0010;
        tick();
        req = '0;
        repeat (6) tick();
        vectors++;
        if (gnt1_cnt - g10 != 0) begin
            miscompares++;
            $display("FAIL pulse_granted: req1 grants %0d, required 0", gnt1_cnt - g10);
        end
        vectors++;
        if ((rom_en_cnt - en0) != 1 || (hs_cnt - hs0) != 1) begin
            miscompares++;
            $display("FAIL pulse_counts: rom_en=%0d responses=%0d, required 1 1",
                     rom_en_cnt - en0, hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_single(0, 3);
        test_single(2, 15);
        test_single(3, 0);
        test_all_req();
        test_backpressure();
        test_reset_capture();
        test_ignore_pulse();
        vectors++;
        if (exp_gnt_q.size() != 0 || exp_rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: gnt pending %0d rsp pending %0d, required 0 0",
                     exp_gnt_q.size(), exp_rsp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter ADDR_W, default 4: ROM address width.
REQ-003 Parameter DATA_W, default 16: ROM data width.
REQ-004 Ports SHALL be exactly:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request, held until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  clog2(NUM_REQ)  index of the requester owning the response.
- rsp_data  out  DATA_W  read data.
- busy  out  1  high in any state except IDLE.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM registered output, valid one cycle after rom_en sampled high.

Function
REQ-005 FSM states SHALL be IDLE, READ, CAPTURE and RESP; all outputs SHALL be registered.
REQ-006 IDLE: when any req bit is high at an edge, the block SHALL select a winner, latch its id and address, pulse gnt for exactly the following cycle, and enter READ.
REQ-007 READ (1 cycle): rom_en=1 and rom_addr=latched address; the next state is CAPTURE; rom_en SHALL be 0 in every other state.
REQ-008 CAPTURE (1 cycle): rom_data SHALL be registered into rsp_data; the next state is RESP.
REQ-009 RESP: rsp_valid=1 while rsp_data and rsp_id are held stable until an edge with rsp_ready=1.
- On that edge, if any req is high, the block arbitrates as in IDLE and enters READ; otherwise it enters IDLE.
REQ-010 Latency SHALL be 3 cycles from the req-sampling edge to rsp_valid high.
- Peak throughput SHALL be one read per 3 cycles with rsp_ready tied high.
REQ-011 req changes outside IDLE and outside the handshake edge SHALL be ignored; a req dropped before grant SHALL leave no trace.
REQ-012 rsp_ready high in any state other than RESP SHALL have no effect.
REQ-013 Addresses 0 and 2^ADDR_W-1 SHALL pass to rom_addr unmodified, with no wrap or offset.
REQ-014 gnt SHALL never have more than one bit set, and SHALL be all-zero except in the first cycle of READ.

Reset
REQ-015 With rst high at an edge, the block SHALL be in state IDLE with gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rom_en=0, rom_addr=0 and busy=0.
- The priority pointer SHALL be set to NUM_REQ-1 so that requester 0 has highest priority first.
REQ-016 Reset in any state SHALL abandon the transaction in flight; no rsp_valid SHALL follow for it.

Configuration
REQ-017 Macro ROM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: round-robin; the search starts at last granted index+1 modulo NUM_REQ, and the pointer updates on each grant.
- Undefined: fixed priority, lowest index wins, no pointer register.

Structure
REQ-018 A shared package rom_arb_pkg SHALL hold the FSM state encoding and the id-width constant function.
REQ-019 Winner selection SHALL be a sub-module rom_arb_select, covering both policies and combinational except for the pointer.

Verification
The bench SHALL use a ROM model with location k = 16'h1000+k and latency 1.
REQ-020 req=4'b0001, addr0=3, rsp_ready=1 -> gnt=0001 for 1 cycle; rom_addr=3; rsp_valid 3 cycles later with rsp_data=16'h1003 and rsp_id=0.
REQ-021 req=4'b1111 held with addrs 0,5,10,15 and round-robin -> grant order 0,1,2,3,0; data 1000,1005,100A,100F. With the macro undefined -> repeated grants to 0 only.
REQ-022 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; no new gnt; release -> next grant on the same edge.
REQ-023 rst asserted during CAPTURE -> all outputs zero next cycle, and no rsp_valid for the abandoned read.
REQ-024 req1 pulsed for 1 cycle while busy in READ -> never granted; rom_en count equals the response count.
